// File: rtl/acc_ctrl_seq.sv
// Multi-cycle fetch/decode/execute control sequencer for the 8-bit accumulator processor.
// Optional single-step mode (PAUSE state, step input) is enabled by defining ACC_CTRL_SINGLE_STEP_EN.
module acc_ctrl_seq #(
  parameter int DW     = 8,
  parameter int MEM_TO = 15
) (
  input  logic          clk,
  input  logic          clr,
`ifdef ACC_CTRL_SINGLE_STEP_EN
  input  logic          step,
`endif
  input  logic [DW-1:0] mem_data,
  input  logic          mem_rdy,
  input  logic          acc_zero,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          addr_sel,
  output logic [DW-5:0] op_addr,
  output logic          pc_inc,
  output logic          pc_ld,
  output logic          en_da,
  output logic [2:0]    alu_op,
  output logic          halted,
  output logic          fault
);

  localparam int            CW      = (MEM_TO > 1) ? $clog2(MEM_TO + 1) : 1;
  localparam bit            TO_EN   = (MEM_TO > 0);
  localparam logic [CW-1:0] TO_LAST = CW'((MEM_TO > 0) ? MEM_TO - 1 : 0);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_CLA = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_CLR  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_RDOP   = 3'd3,
    S_WROP   = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
`ifdef ACC_CTRL_SINGLE_STEP_EN
    ,
    S_PAUSE  = 3'd7
`endif
  } state_t;

  // Where an instruction goes once it has finished: straight to the next fetch,
  // or into PAUSE to wait for a step request.
`ifdef ACC_CTRL_SINGLE_STEP_EN
  localparam state_t S_RESUME = S_PAUSE;
`else
  localparam state_t S_RESUME = S_FETCH;
`endif

  state_t        state;
  logic [DW-1:0] ir;
  logic [3:0]    opcode;
  logic [CW-1:0] to_cnt;
  logic          to_expired;

  assign opcode     = ir[DW-1:DW-4];
  assign to_expired = TO_EN && (to_cnt == TO_LAST) && !mem_rdy;

  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_sel = ALU_ADD;
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      default: alu_sel = ALU_PASS;
    endcase
  endfunction

  // Counter is zero outside the memory-wait states, so it is clear on every entry.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= S_IDLE;
      ir     <= '0;
      to_cnt <= '0;
    end else begin
      to_cnt <= '0;
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (mem_rdy) begin
            ir    <= mem_data;
            state <= S_DECODE;
          end else if (to_expired) begin
            state <= S_FAULT;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_AND: state <= S_RDOP;
            OP_STA:                         state <= S_WROP;
            OP_HLT:                         state <= S_HALT;
            default:                        state <= S_RESUME;
          endcase
        end
        S_RDOP, S_WROP: begin
          if (mem_rdy) begin
            state <= S_RESUME;
          end else if (to_expired) begin
            state <= S_FAULT;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
`ifdef ACC_CTRL_SINGLE_STEP_EN
        S_PAUSE: if (step) state <= S_FETCH;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode state directly so clr kills every strobe without waiting for an edge.
  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    op_addr  = ir[DW-5:0];
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    en_da    = 1'b0;
    alu_op   = ALU_PASS;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state)
      S_FETCH: mem_rd = 1'b1;
      S_DECODE: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_STA: pc_inc = 1'b1;
          OP_JMP: pc_ld = 1'b1;
          OP_JZ: begin
            pc_ld  = acc_zero;
            pc_inc = !acc_zero;
          end
          OP_CLA: begin
            en_da  = 1'b1;
            alu_op = ALU_CLR;
            pc_inc = 1'b1;
          end
          OP_HLT: ;
          default: pc_inc = 1'b1;
        endcase
      end
      S_RDOP: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        if (mem_rdy) begin
          en_da  = 1'b1;
          alu_op = alu_sel(opcode);
        end
      end
      S_WROP: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_acc_ctrl_seq.sv
// Directed bench for acc_ctrl_seq: an instruction-level model expands each instruction into
// its expected per-cycle output trace, and a negedge process compares the DUT against it.
module tb_acc_ctrl_seq;
  localparam int DW     = 8;
  localparam int MEM_TO = 15;
`ifdef ACC_CTRL_SINGLE_STEP_EN
  localparam int HALT_CYC = 11;
`else
  localparam int HALT_CYC = 9;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] mem_data = 8'h00;
  logic       mem_rdy = 1'b0;
  logic       acc_zero = 1'b0;
`ifdef ACC_CTRL_SINGLE_STEP_EN
  logic       step_in = 1'b1;
`endif
  logic       mem_rd, mem_wr, addr_sel, pc_inc, pc_ld, en_da, halted, fault;
  logic [3:0] op_addr;
  logic [2:0] alu_op;

  acc_ctrl_seq #(.DW(DW), .MEM_TO(MEM_TO)) dut (
    .clk      (clk),
    .clr      (clr),
`ifdef ACC_CTRL_SINGLE_STEP_EN
    .step     (step_in),
`endif
    .mem_data (mem_data),
    .mem_rdy  (mem_rdy),
    .acc_zero (acc_zero),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .addr_sel (addr_sel),
    .op_addr  (op_addr),
    .pc_inc   (pc_inc),
    .pc_ld    (pc_ld),
    .en_da    (en_da),
    .alu_op   (alu_op),
    .halted   (halted),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic [3:0] op_addr;
    logic       pc_inc;
    logic       pc_ld;
    logic       en_da;
    logic [2:0] alu_op;
    logic       halted;
    logic       fault;
  } exp_t;

  exp_t       got;
  exp_t       expq[$];
  logic [2:0] alu_log[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         tcyc = 0;
  int         n_pcinc = 0, n_pcld = 0, n_enda = 0, n_wr = 0, first_halt = 0;
  logic [7:0] m_ir = 8'h00;
  string      phase = "init";

  assign got = {mem_rd, mem_wr, addr_sel, op_addr, pc_inc, pc_ld, en_da, alu_op, halted, fault};

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] x);
    n_chk++;
    if (g !== x) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, tcyc, g, x);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      exp_t e;
      e = expq.pop_front();
      chk(phase, 32'(got), 32'(e));
      if (pc_inc) n_pcinc++;
      if (pc_ld) n_pcld++;
      if (mem_wr) n_wr++;
      if (en_da) begin
        n_enda++;
        alu_log.push_back(alu_op);
      end
      if (halted && first_halt == 0) first_halt = tcyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", tcyc);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    e.op_addr = m_ir[3:0];
    return e;
  endfunction

  task automatic clr_counts();
    n_pcinc = 0; n_pcld = 0; n_enda = 0; n_wr = 0; first_halt = 0; tcyc = 0;
    alu_log.delete();
  endtask

  task automatic step(input logic rdy, input logic [7:0] d, input logic az, input exp_t e);
    mem_rdy  = rdy;
    mem_data = d;
    acc_zero = az;
    tcyc++;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr  = 1'b1;
    m_ir = 8'h00;
    @(posedge clk);
    #1;
    chk("reset_outputs", 32'(got), 32'h0);
    clr = 1'b0;
    step(1'b1, 8'hFF, 1'b0, blank());  // IDLE cycle, mem_rdy ignored
    clr_counts();
  endtask

  // Expected trace of one instruction: fetch (fw waits), decode, then operand access (ow waits).
  task automatic run_instr(input logic [7:0] ins, input int fw, input int ow, input logic az);
    exp_t e;
    logic [3:0] op;
    e = blank();
    e.mem_rd = 1'b1;
    repeat (fw) step(1'b0, 8'h00, az, e);
    step(1'b1, ins, az, e);
    m_ir = ins;
    op = ins[7:4];
    e = blank();
    if (op == 4'h6) e.pc_ld = 1'b1;
    else if (op == 4'h7) begin
      e.pc_ld  = az;
      e.pc_inc = !az;
    end else if (op == 4'h8) begin
      e.en_da  = 1'b1;
      e.alu_op = 3'd4;
      e.pc_inc = 1'b1;
    end else if (op != 4'hF) e.pc_inc = 1'b1;
    step(1'b1, 8'h00, az, e);
    if (op >= 4'h1 && op <= 4'h5) begin
      e = blank();
      e.addr_sel = 1'b1;
      if (op == 4'h2) e.mem_wr = 1'b1;
      else e.mem_rd = 1'b1;
      repeat (ow) step(1'b0, 8'h00, az, e);
      if (op != 4'h2) begin
        e.en_da  = 1'b1;
        e.alu_op = (op == 4'h1) ? 3'd0 : (op == 4'h3) ? 3'd1 : (op == 4'h4) ? 3'd2 : 3'd3;
      end
      step(1'b1, 8'h07, az, e);
    end
`ifdef ACC_CTRL_SINGLE_STEP_EN
    if (op != 4'hF) step(1'b0, 8'h00, az, blank());  // PAUSE, step_in high
`endif
  endtask

  initial begin
    exp_t e;

    phase = "prog1";
    do_reset();
    run_instr(8'h15, 0, 0, 1'b0);
    run_instr(8'h36, 0, 0, 1'b0);
    run_instr(8'hF0, 0, 0, 1'b0);
    e = blank();
    e.halted = 1'b1;
    step(1'b1, 8'h11, 1'b0, e);
    step(1'b0, 8'h11, 1'b0, e);
    step(1'b1, 8'h11, 1'b1, e);
    chk("prog1_halt_cycle", first_halt, HALT_CYC);
    chk("prog1_pc_inc_cnt", n_pcinc, 2);
    chk("prog1_en_da_cnt", n_enda, 2);
    chk("prog1_alu_first", (alu_log.size() > 0) ? alu_log[0] : 3'd7, 3'd0);
    chk("prog1_alu_second", (alu_log.size() > 1) ? alu_log[1] : 3'd7, 3'd1);

    phase = "sta_wait";
    do_reset();
    run_instr(8'h2A, 0, 3, 1'b0);
    chk("sta_wr_cycles", n_wr, 4);
    chk("sta_no_en_da", n_enda, 0);

    phase = "jz_taken";
    do_reset();
    run_instr(8'h74, 0, 0, 1'b1);
    chk("jz_taken_pc_ld", n_pcld, 1);
    chk("jz_taken_pc_inc", n_pcinc, 0);
    phase = "jz_not_taken";
    clr_counts();
    run_instr(8'h74, 0, 0, 1'b0);
    chk("jz_not_pc_inc", n_pcinc, 1);
    chk("jz_not_pc_ld", n_pcld, 0);

    phase = "mix";
    run_instr(8'h69, 0, 0, 1'b0);
    run_instr(8'h00, 2, 0, 1'b0);
    run_instr(8'h9C, 0, 0, 1'b1);
    run_instr(8'h80, 1, 0, 1'b0);
    run_instr(8'h43, 0, 1, 1'b0);
    run_instr(8'h51, 0, 2, 1'b1);
    run_instr(8'h3E, 0, 0, 1'b0);

    phase = "timeout";
    do_reset();
    e = blank();
    e.mem_rd = 1'b1;
    repeat (MEM_TO) step(1'b0, 8'h00, 1'b0, e);
    e = blank();
    e.fault = 1'b1;
    step(1'b1, 8'h15, 1'b0, e);
    step(1'b0, 8'h15, 1'b0, e);
    step(1'b1, 8'h15, 1'b0, e);
    #1;
    chk("fault_sticky", fault, 1'b1);
    chk("fault_no_rd", mem_rd, 1'b0);

    phase = "timeout_edge";
    do_reset();
    run_instr(8'h00, MEM_TO - 1, 0, 1'b0);
    chk("edge_no_fault", fault, 1'b0);
    run_instr(8'h80, 0, 0, 1'b0);

    phase = "clr_abort";
    do_reset();
    run_instr(8'h00, 0, 0, 1'b0);
    e = blank();
    e.mem_rd = 1'b1;
    step(1'b1, 8'h15, 1'b0, e);
    m_ir = 8'h15;
    e = blank();
    e.pc_inc = 1'b1;
    step(1'b0, 8'h00, 1'b0, e);
    mem_rdy = 1'b1;
    #1;
    chk("rdop_rd_before", mem_rd, 1'b1);
    chk("rdop_en_before", en_da, 1'b1);
    clr = 1'b1;
    #1;
    chk("rdop_rd_after_clr", mem_rd, 1'b0);
    chk("rdop_en_after_clr", en_da, 1'b0);
    do_reset();
    mem_rdy = 1'b0;
    #1;
    chk("fetch_after_clr", mem_rd, 1'b1);
    e = blank();
    e.mem_rd = 1'b1;
    step(1'b0, 8'h00, 1'b0, e);

`ifdef ACC_CTRL_SINGLE_STEP_EN
    phase = "single_step";
    do_reset();
    e = blank();
    e.mem_rd = 1'b1;
    step(1'b1, 8'h00, 1'b0, e);
    m_ir = 8'h00;
    e = blank();
    e.pc_inc = 1'b1;
    step_in = 1'b0;
    step(1'b1, 8'h00, 1'b0, e);
    repeat (10) step(1'b1, 8'h00, 1'b0, blank());
    step_in = 1'b1;
    step(1'b0, 8'h00, 1'b0, blank());
    step_in = 1'b0;
    mem_rdy = 1'b0;
    #1;
    chk("step_starts_fetch", mem_rd, 1'b1);
    e = blank();
    e.mem_rd = 1'b1;
    step(1'b0, 8'h00, 1'b0, e);
    step_in = 1'b1;
`endif

    @(negedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/acc_ctrl_seq.md
Name: acc_ctrl_seq

Overview:
Multi-cycle control sequencer for the 8-bit accumulator processor.
- Fetches instructions over a req/rdy memory handshake.
- Holds the instruction register and decodes a 4-bit opcode.
- Drives the accumulator load enable (en_da), ALU op select, PC controls and memory strobes.
- Sits between program/data memory, PC, ALU and the accumulator register.

Parameters:
- DW, 8, instruction/data width; opcode = ir[DW-1:DW-4], operand address = ir[DW-5:0].
- MEM_TO, 15, maximum cycles waiting for mem_rdy before FAULT; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous reset, active-high.
- mem_data  input  DW  memory read data; sampled as an instruction in FETCH.
- mem_rdy  input  1  memory completes the current rd/wr this cycle.
- acc_zero  input  1  accumulator == 0, from the datapath.
- mem_rd  output  1  read strobe, held until mem_rdy.
- mem_wr  output  1  write strobe (accumulator to memory), held until mem_rdy.
- addr_sel  output  1  0 = PC drives the address, 1 = ir operand drives the address.
- op_addr  output  DW-4  operand address, ir[DW-5:0].
- pc_inc  output  1  PC increment pulse.
- pc_ld  output  1  PC load-from-op_addr pulse.
- en_da  output  1  accumulator load enable pulse.
- alu_op  output  3  0 PASS, 1 ADD, 2 SUB, 3 AND, 4 CLR.
- halted  output  1  in HALT state.
- fault  output  1  memory timeout occurred (sticky).

Behaviour:
- States: IDLE, FETCH, DECODE, RDOP, WROP, HALT, FAULT. State register, ir and timeout counter are clocked.
- Outputs are combinational from state/ir/mem_rdy.
- Reset (clr=1, asynchronous): state=IDLE, ir=0, counter=0; every output 0. Deassert leads to IDLE, then FETCH on the next edge.
- IDLE: no outputs asserted; next state FETCH.
- FETCH: mem_rd=1, addr_sel=0.
  - If mem_rdy=1: ir <= mem_data on that edge; next state DECODE.
  - Otherwise stay.
- DECODE: exactly one cycle; acts on opcode ir[7:4]:
  - 0 NOP, and all undefined codes 9-E: pc_inc; go to FETCH.
  - 1 LDA, 3 ADD, 4 SUB, 5 AND: pc_inc; go to RDOP.
  - 2 STA: pc_inc; go to WROP.
  - 6 JMP: pc_ld; go to FETCH.
  - 7 JZ: pc_ld if acc_zero=1, else pc_inc; go to FETCH.
  - 8 CLA: en_da=1, alu_op=CLR, pc_inc; go to FETCH.
  - F HLT: no pulses; go to HALT.
- RDOP: mem_rd=1, addr_sel=1.
  - On mem_rdy: en_da=1 in the same cycle with alu_op PASS/ADD/SUB/AND for LDA/ADD/SUB/AND; then FETCH.
- WROP: mem_wr=1, addr_sel=1; on mem_rdy go to FETCH. en_da stays 0.
- HALT: halted=1; all strobes 0; exited only by clr.
- FAULT: fault=1; all strobes 0; exited only by clr.
- pc_inc and pc_ld are never high together. en_da is high for exactly one cycle per LDA/ADD/SUB/AND/CLA.
- Latency with a zero-wait memory (mem_rdy high on the first strobe cycle):
  - NOP/JMP/JZ/CLA: 2 cycles.
  - LDA/ALU/STA: 3 cycles.
  - Each wait cycle adds 1.
- Timeout:
  - Counter clears on entering FETCH/RDOP/WROP and whenever mem_rdy=1.
  - It increments each cycle in those states with mem_rdy=0.
  - When the count reaches MEM_TO with mem_rdy still 0, go to FAULT.
  - mem_rdy arriving in the same cycle the limit is reached wins: normal completion.
- Ignore mem_rdy in IDLE, DECODE, HALT and FAULT.
- clr mid-operation aborts any strobe immediately, asynchronously.

Optional Feature:
- Macro ACC_CTRL_SINGLE_STEP_EN.
- When defined:
  - Add input step (1 bit) and state PAUSE.
  - Every transition that would enter FETCH from DECODE/RDOP/WROP enters PAUSE instead. The IDLE entry to FETCH is unchanged.
  - PAUSE asserts no strobes and leaves FETCH on a cycle where step=1 (level sampled).
  - The timeout counter is idle in PAUSE.
- When undefined: no step port, no PAUSE state; behaviour as above.

Test Plan:
- Reset then program {0x15, 0x36, 0xF0}; mem[5]=0x07, mem[6]=0x03, zero-wait memory.
  - en_da pulses with alu_op=PASS, then ADD.
  - halted=1 on the 9th cycle after FETCH entry; pc_inc pulses 2 times.
- STA 0x2A with mem_rdy delayed 3 cycles.
  - mem_wr high for 4 cycles with addr_sel=1 and op_addr=0xA; en_da never high.
- JZ 0x74 with acc_zero=1 gives pc_ld=1, pc_inc=0.
  - Repeat with acc_zero=0: pc_inc=1, pc_ld=0.
- mem_rdy held 0 in FETCH with MEM_TO=15.
  - fault=1 after 15 wait cycles, mem_rd drops, state stuck.
  - Variant with mem_rdy arriving exactly at count 15: no fault.
- Assert clr while in RDOP with mem_rd high.
  - mem_rd and en_da drop to 0 asynchronously.
  - After release: IDLE, then FETCH with mem_rd=1 on the next cycle.
- With ACC_CTRL_SINGLE_STEP_EN: after NOP, no mem_rd while step=0 for 10 cycles.
  - step=1 for one cycle starts the next FETCH.
